// File: rtl/hus_pkg.sv
// Shared types and helpers for the HUS sample stream: FSM encoding, channel limit
// and the effective sample-period rule.
package hus_pkg;

    typedef enum logic {ST_IDLE, ST_EMIT} hus_state_e;

    localparam int unsigned HUS_MAX_CHANNELS = 4;

    // A frame needs CHANNELS output cycles plus one idle cycle before the next strobe.
    function automatic int unsigned hus_eff_period(int unsigned rate, int unsigned channels);
        return (rate + 1 > channels + 1) ? rate + 1 : channels + 1;
    endfunction

endpackage

// File: rtl/hus_stream_fifo.sv
// Single-clock sample FIFO with registered read data, async clear and a used counter.
// Storage is not reset; only pointers, count and read register are.
module hus_stream_fifo #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          pop_i,
    output logic [DW-1:0] rd_data_o,
    output logic [AW:0]   used_o,
    output logic          full_o
);

    localparam int unsigned Depth = 2 ** AW;
    localparam int unsigned UW    = AW + 1;

    logic [DW-1:0] mem_q [Depth];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   used_q, used_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          do_push, do_pop;

    assign full_o    = (used_q == UW'(Depth));
    assign used_o    = used_q;
    assign rd_data_o = rd_data_q;

    // A push while full is dropped; the caller flags the overflow.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && (used_q != '0);

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        used_d    = used_q;
        rd_data_d = rd_data_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            rd_data_d = mem_q[rd_ptr_q];
        end
        case ({do_push, do_pop})
            2'b10:   used_d = used_q + 1'b1;
            2'b01:   used_d = used_q - 1'b1;
            default: used_d = used_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            used_q    <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            used_q    <= used_d;
            rd_data_q <= rd_data_d;
        end
    end

endmodule

// File: rtl/hus_stream.sv
// N-channel PCM sample stream: FIFO plus sample-rate/tick generator that pops one
// frame per sample period and strobes it out to the DACs one channel per cycle.
module hus_stream
    import hus_pkg::*;
#(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned DW       = 16,
    parameter int unsigned AW       = 8,
    parameter int unsigned RATE_W   = 8,
    parameter int unsigned TICK_W   = 10
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                wr_en,
    input  logic [DW-1:0]       wr_data,
    input  logic [RATE_W-1:0]   sample_rate,
    input  logic [TICK_W-1:0]   tick_rate,
    input  logic [AW:0]         low_wm,
    input  logic                hold_mode,
    input  logic                clr_flags,
    output logic [AW:0]         used,
    output logic                full,
    output logic                dreq,
    output logic [CHANNELS-1:0] dac_we,
    output logic [DW-1:0]       dac_data,
    output logic                tick_stb,
    output logic                underrun,
    output logic                overflow
);

    localparam int unsigned PW = RATE_W + 1;
    localparam int unsigned UW = AW + 1;
    localparam int unsigned KW = 2;

    hus_state_e          state_q, state_d;
    logic [KW-1:0]       k_q, k_d;
    logic [PW-1:0]       rc_q, rc_d;
    logic [PW-1:0]       period_q, period_d;
    logic [TICK_W-1:0]   fc_q, fc_d;
    logic [TICK_W-1:0]   tick_rate_q, tick_rate_d;
    logic                normal_q, normal_d;
    logic                hold_q, hold_d;
    logic [DW-1:0]       last_q [HUS_MAX_CHANNELS];
    logic [DW-1:0]       last_d [HUS_MAX_CHANNELS];
    logic [CHANNELS-1:0] dac_we_q, dac_we_d;
    logic [DW-1:0]       dac_hold_q, dac_hold_d;
    logic                fifo_sel_q, fifo_sel_d;
    logic                tick_q, tick_d;
    logic                underrun_q, underrun_d;
    logic                overflow_q, overflow_d;
    logic                strobe, pop, underrun_set;
    logic [DW-1:0]       fifo_rd_data;

    hus_stream_fifo #(
        .DW (DW),
        .AW (AW)
    ) u_fifo (
        .clk_i     (clk),
        .rst_ni    (reset_n),
        .push_i    (wr_en),
        .wr_data_i (wr_data),
        .pop_i     (pop),
        .rd_data_o (fifo_rd_data),
        .used_o    (used),
        .full_o    (full)
    );

    assign dreq     = (used < low_wm);
    assign dac_we   = dac_we_q;
    // Normal frames drive straight from the FIFO read register; underrun frames from dac_hold_q.
    assign dac_data = fifo_sel_q ? fifo_rd_data : dac_hold_q;
    assign tick_stb = tick_q;
    assign underrun = underrun_q;
    assign overflow = overflow_q;

    assign strobe = enable && (rc_q == '0) && (state_q == ST_IDLE);

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        period_d     = period_q;
        tick_rate_d  = tick_rate_q;
        fc_d         = fc_q;
        normal_d     = normal_q;
        hold_d       = hold_q;
        last_d       = last_q;
        dac_we_d     = '0;
        dac_hold_d   = '0;
        fifo_sel_d   = 1'b0;
        tick_d       = 1'b0;
        pop          = 1'b0;
        underrun_set = 1'b0;

        if (!enable) begin
            rc_d = '0;
        end else if (rc_q >= period_q - 1'b1) begin
            rc_d = '0;
        end else begin
            rc_d = rc_q + 1'b1;
        end
        // Rates only take effect at a period boundary.
        if (rc_d == '0) begin
            period_d    = PW'(hus_eff_period(32'(sample_rate), CHANNELS));
            tick_rate_d = tick_rate;
        end
        if (!enable) begin
            fc_d = '0;
        end

        case (state_q)
            ST_IDLE: begin
                if (strobe) begin
                    normal_d     = (used >= UW'(CHANNELS));
                    hold_d       = hold_mode;
                    pop          = normal_d;
                    fifo_sel_d   = normal_d;
                    dac_hold_d   = (!normal_d && hold_mode) ? last_q[0] : '0;
                    dac_we_d     = CHANNELS'(1);
                    underrun_set = !normal_d;
                    tick_d       = (fc_q == tick_rate_q);
                    fc_d         = tick_d ? '0 : fc_q + 1'b1;
                    k_d          = '0;
                    state_d      = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (normal_q) begin
                    last_d[k_q] = fifo_rd_data;
                end
                if (k_q == KW'(CHANNELS - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    k_d        = k_q + 1'b1;
                    pop        = normal_q;
                    fifo_sel_d = normal_q;
                    dac_hold_d = (!normal_q && hold_q) ? last_q[k_d] : '0;
                    dac_we_d   = CHANNELS'(1) << k_d;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        underrun_d = underrun_set || (underrun_q && !clr_flags);
        overflow_d = (wr_en && full) || (overflow_q && !clr_flags);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            rc_q        <= '0;
            period_q    <= PW'(CHANNELS + 1);
            tick_rate_q <= '0;
            fc_q        <= '0;
            normal_q    <= 1'b0;
            hold_q      <= 1'b0;
            last_q      <= '{default: '0};
            dac_we_q    <= '0;
            dac_hold_q  <= '0;
            fifo_sel_q  <= 1'b0;
            tick_q      <= 1'b0;
            underrun_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            rc_q        <= rc_d;
            period_q    <= period_d;
            tick_rate_q <= tick_rate_d;
            fc_q        <= fc_d;
            normal_q    <= normal_d;
            hold_q      <= hold_d;
            last_q      <= last_d;
            dac_we_q    <= dac_we_d;
            dac_hold_q  <= dac_hold_d;
            fifo_sel_q  <= fifo_sel_d;
            tick_q      <= tick_d;
            underrun_q  <= underrun_d;
            overflow_q  <= overflow_d;
        end
    end

endmodule

// File: tb/tb_hus_stream.sv
// Self-checking bench for hus_stream: directed scenarios plus random traffic, all
// checked every cycle against a frame-level queue model.
module tb_hus_stream;

    localparam int C     = 2;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic          wr_en;
    logic [15:0]   wr_data;
    logic [7:0]    sample_rate;
    logic [9:0]    tick_rate;
    logic [AW:0]   low_wm;
    logic          hold_mode;
    logic          clr_flags;
    logic [AW:0]   used;
    logic          full;
    logic          dreq;
    logic [C-1:0]  dac_we;
    logic [15:0]   dac_data;
    logic          tick_stb;
    logic          underrun;
    logic          overflow;

    int n_chk = 0;
    int n_bad = 0;

    hus_stream #(
        .CHANNELS (C),
        .DW       (16),
        .AW       (AW),
        .RATE_W   (8),
        .TICK_W   (10)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .sample_rate (sample_rate),
        .tick_rate   (tick_rate),
        .low_wm      (low_wm),
        .hold_mode   (hold_mode),
        .clr_flags   (clr_flags),
        .used        (used),
        .full        (full),
        .dreq        (dreq),
        .dac_we      (dac_we),
        .dac_data    (dac_data),
        .tick_stb    (tick_stb),
        .underrun    (underrun),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [15:0] q[$];
    logic [15:0] frame [C];
    logic [15:0] last_m [C];
    int          pops_left;
    int          emit_idx;
    int          en_cnt;
    int          frame_no;
    bit          uf_m, of_m, tick_m;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        pops_left = 0;
        emit_idx  = -1;
        en_cnt    = 0;
        frame_no  = 0;
        uf_m      = 0;
        of_m      = 0;
        tick_m    = 0;
        for (int k = 0; k < C; k++) begin
            last_m[k] = '0;
            frame[k]  = '0;
        end
    endtask

    // Applies the inputs present at a rising edge to the model.
    task automatic model_edge();
        int used_before, per;
        bit busy, strobe, normal, uf_set, of_set;
        used_before = q.size() + pops_left;
        busy = (emit_idx >= 0);
        if (pops_left > 0) pops_left--;
        if (busy) begin
            emit_idx++;
            if (emit_idx == C) emit_idx = -1;
        end
        per = (int'(sample_rate) + 1 > C + 1) ? int'(sample_rate) + 1 : C + 1;
        strobe = enable && !busy && (en_cnt % per == 0);
        en_cnt = enable ? en_cnt + 1 : 0;
        if (!enable) frame_no = 0;
        tick_m = 0;
        uf_set = 0;
        of_set = 0;
        if (strobe) begin
            frame_no++;
            tick_m = (frame_no % (int'(tick_rate) + 1) == 0);
            normal = (used_before >= C);
            for (int k = 0; k < C; k++) begin
                if (normal) begin
                    frame[k]  = q.pop_front();
                    last_m[k] = frame[k];
                end else begin
                    frame[k] = hold_mode ? last_m[k] : 16'h0;
                end
            end
            if (normal) pops_left = C - 1;
            else uf_set = 1;
            emit_idx = 0;
        end
        if (wr_en) begin
            if (used_before == DEPTH) of_set = 1;
            else q.push_back(wr_data);
        end
        uf_m = uf_set || (uf_m && !clr_flags);
        of_m = of_set || (of_m && !clr_flags);
    endtask

    task automatic check_outputs();
        int ue;
        ue = q.size() + pops_left;
        check_eq("used", used, ue);
        check_eq("full", full, ue == DEPTH);
        check_eq("dreq", dreq, ue < int'(low_wm));
        check_eq("dac_we", dac_we, (emit_idx >= 0) ? (1 << emit_idx) : 0);
        if (emit_idx >= 0) check_eq("dac_data", dac_data, frame[emit_idx]);
        check_eq("tick_stb", tick_stb, tick_m);
        check_eq("underrun", underrun, uf_m);
        check_eq("overflow", overflow, of_m);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic push_word(input logic [15:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic rand_cycle(input int wr_pct);
        wr_en     = ($urandom_range(0, 99) < wr_pct);
        wr_data   = 16'($urandom);
        clr_flags = ($urandom_range(0, 19) == 0);
        if ($urandom_range(0, 9) == 0) hold_mode = ~hold_mode;
        step();
        wr_en     = 1'b0;
        clr_flags = 1'b0;
    endtask

    task automatic reset_check();
        reset_n = 1'b0;
        #1;
        check_eq("rst_used", used, 0);
        check_eq("rst_full", full, 0);
        check_eq("rst_dac_we", dac_we, 0);
        check_eq("rst_dac_data", dac_data, 0);
        check_eq("rst_tick", tick_stb, 0);
        check_eq("rst_underrun", underrun, 0);
        check_eq("rst_overflow", overflow, 0);
        model_reset();
        enable = 1'b0;
        wr_en  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        low_wm  = 5'd4;
        #1;
        check_eq("rst_dreq", dreq, 1);
    endtask

    initial begin
        model_reset();
        reset_n     = 1'b0;
        enable      = 1'b0;
        wr_en       = 1'b0;
        wr_data     = '0;
        sample_rate = 8'd9;
        tick_rate   = 10'd0;
        low_wm      = 5'd4;
        hold_mode   = 1'b1;
        clr_flags   = 1'b0;
        #12;
        check_eq("init_used", used, 0);
        check_eq("init_dac_we", dac_we, 0);
        check_eq("init_dreq", dreq, 1);
        @(negedge clk);
        reset_n = 1'b1;
        idle(2);

        // Two full frames, then underrun repeats (hold) and zeros
        push_word(16'hA000);
        push_word(16'hA001);
        push_word(16'hB000);
        push_word(16'hB001);
        idle(2);
        enable = 1'b1;
        idle(25);
        hold_mode = 1'b0;
        idle(10);
        enable = 1'b0;
        idle(4);

        // Partial frame stays put until completed
        hold_mode = 1'b1;
        push_word(16'hC000);
        enable = 1'b1;
        idle(12);
        push_word(16'hC001);
        idle(12);
        enable = 1'b0;
        idle(4);

        // Overflow, then simultaneous push/pop at period 3
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) push_word(16'(16'h1000 + i));
        check_eq("ovf_used", used, DEPTH);
        check_eq("ovf_full", full, 1);
        check_eq("ovf_flag", overflow, 1);
        sample_rate = 8'd0;
        idle(2);
        enable = 1'b1;
        for (int i = 0; i < 24; i++) rand_cycle(100);
        enable = 1'b0;
        idle(4);

        // Tick every third frame, underruns included
        tick_rate = 10'd2;
        idle(2);
        enable = 1'b1;
        for (int i = 0; i < 30; i++) rand_cycle(30);
        enable = 1'b0;
        idle(4);

        // Reset in the middle of a frame
        push_word(16'hD000);
        push_word(16'hD001);
        enable = 1'b1;
        step();
        reset_check();
        idle(3);

        // Random traffic
        for (int s = 0; s < 150; s++) begin
            enable      = 1'b0;
            sample_rate = 8'($urandom_range(0, 12));
            tick_rate   = 10'($urandom_range(0, 3));
            low_wm      = 5'($urandom_range(0, 17));
            for (int i = 0; i < 4 + int'($urandom_range(0, 2)); i++) rand_cycle(50);
            enable = 1'b1;
            for (int i = 0; i < 5 + int'($urandom_range(0, 35)); i++) rand_cycle(45);
        end
        enable = 1'b0;
        idle(4);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
